// File: rtl/connect4_turn_controller_pkg.sv
// Shared types and constants for the 4x4 Connect4 turn controller:
// FSM states, board geometry, button patterns and the press decoder.
package connect4_pkg;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int CELLS = 16;

    localparam logic [4:0] NO_POS = 5'b11111;

    localparam logic [3:0] BTN_NONE = 4'b1111;
    localparam logic [3:0] BTN_COL0 = 4'b1110;
    localparam logic [3:0] BTN_COL1 = 4'b1101;
    localparam logic [3:0] BTN_COL2 = 4'b1011;
    localparam logic [3:0] BTN_COL3 = 4'b0111;

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_WAIT_PRESS   = 3'd1,
        S_PLACE        = 3'd2,
        S_WAIT_RELEASE = 3'd3,
        S_FULL         = 3'd4,
        S_DONE         = 3'd5
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [1:0] col;
    } press_t;

    // Only a single low button counts as a press; chords are ignored.
    function automatic press_t decode_press(input logic [3:0] btn_n);
        press_t p;
        p.valid = 1'b1;
        p.col   = 2'd0;
        case (btn_n)
            BTN_COL0: p.col = 2'd0;
            BTN_COL1: p.col = 2'd1;
            BTN_COL2: p.col = 2'd2;
            BTN_COL3: p.col = 2'd3;
            default: begin
                p.valid = 1'b0;
                p.col   = 2'd0;
            end
        endcase
        return p;
    endfunction

endpackage

// File: rtl/connect4_turn_controller_if.sv
// Button/board-side signal bundle of the turn controller; the controller
// uses the slave view, the board/test side the master view.
interface connect4_turn_controller_if;

    logic        new_game;
    logic [3:0]  btn_n;
    logic        win;
    logic [11:0] counters;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic        wr_player;
    logic        player;
    logic        move_reject;
    logic        board_full;
    logic        game_over;

    modport master (
        output new_game, btn_n, win,
        input  counters, wr_en, wr_addr, wr_player, player,
        input  move_reject, board_full, game_over
    );

    modport slave (
        input  new_game, btn_n, win,
        output counters, wr_en, wr_addr, wr_player, player,
        output move_reject, board_full, game_over
    );

endinterface

// File: rtl/connect4_turn_controller_slot_address.sv
// Combinational drop-slot lookup: column + fill counters -> target cell
// address (row*4 + column) and column-full flag.
module slot_address
    import connect4_pkg::*;
#(
    parameter int ROWS = connect4_pkg::ROWS,
    parameter int COLS = connect4_pkg::COLS
) (
    input  logic [1:0]        col_i,
    input  logic [3*COLS-1:0] counters_i,
    output logic [4:0]        addr_o,
    output logic              full_o
);

    logic [2:0] cnt_s;

    // Select the column counter and form the cell address from it.
    always_comb begin
        cnt_s  = counters_i[3*col_i +: 3];
        full_o = (cnt_s == 3'(ROWS));
        if (full_o) begin
            addr_o = NO_POS;
        end else begin
            addr_o = {cnt_s, col_i};
        end
    end

endmodule

// File: rtl/connect4_turn_controller.sv
// Connect4 turn sequencer: one write per debounced column press, per-column
// fill counters, alternating players, full-board and win termination.
module connect4_turn_controller
    import connect4_pkg::*;
#(
    parameter int ROWS = connect4_pkg::ROWS,
    parameter int COLS = connect4_pkg::COLS
) (
    input  logic                      clk,
    input  logic                      reset_n,
    connect4_turn_controller_if.slave bus
);

    state_e            state_q, state_d;
    logic [3*COLS-1:0] counters_q, counters_d;
    logic [4:0]        moves_q, moves_d;
    logic              player_q, player_d;
    logic [1:0]        col_q, col_d;
    logic              wr_en_q, wr_en_d;
    logic [4:0]        wr_addr_q, wr_addr_d;
    logic              wr_player_q, wr_player_d;
    logic              move_reject_q, move_reject_d;
    logic              board_full_q, board_full_d;
    logic              game_over_q, game_over_d;

    press_t            press_s;
    logic [4:0]        slot_addr_s;
    logic              slot_full_s;

    assign press_s = decode_press(bus.btn_n);

    // Column latch: captured on a valid press, held through PLACE.
    always_comb begin
        if ((state_q == S_WAIT_PRESS) && press_s.valid) begin
            col_d = press_s.col;
        end else begin
            col_d = col_q;
        end
    end

    slot_address #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_slot_address (
        .col_i      (col_d),
        .counters_i (counters_q),
        .addr_o     (slot_addr_s),
        .full_o     (slot_full_s)
    );

    // Next-state, board bookkeeping and next values of the registered outputs.
    always_comb begin
        state_d    = state_q;
        counters_d = counters_q;
        moves_d    = moves_q;
        player_d   = player_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
            end
            S_WAIT_PRESS: begin
                if (bus.win) begin
                    state_d = S_DONE;
                end else if (press_s.valid) begin
                    state_d = S_PLACE;
                end else begin
                    state_d = S_WAIT_PRESS;
                end
            end
            S_PLACE: begin
                // col_d equals col_q here, so slot_full_s refers to the latched column.
                if (!slot_full_s) begin
                    counters_d[3*col_q +: 3] = counters_q[3*col_q +: 3] + 3'd1;
                    moves_d  = moves_q + 5'd1;
                    player_d = ~player_q;
                end else begin
                    counters_d = counters_q;
                end
                if (bus.win) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT_RELEASE;
                end
            end
            S_WAIT_RELEASE: begin
                if (bus.win) begin
                    state_d = S_DONE;
                end else if (bus.btn_n == BTN_NONE) begin
                    if (moves_q == 5'(CELLS)) begin
                        state_d = S_FULL;
                    end else begin
                        state_d = S_WAIT_PRESS;
                    end
                end else begin
                    state_d = S_WAIT_RELEASE;
                end
            end
            S_FULL: begin
                state_d = S_FULL;
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (bus.new_game) begin
            state_d    = S_WAIT_PRESS;
            counters_d = '0;
            moves_d    = 5'd0;
            player_d   = 1'b0;
        end else begin
            state_d = state_d;
        end

        // Outputs are decoded from the state being entered so they register as PLACE/FULL/DONE Moore outputs.
        wr_en_d       = (state_d == S_PLACE) && !slot_full_s;
        move_reject_d = (state_d == S_PLACE) && slot_full_s;
        if (wr_en_d) begin
            wr_addr_d   = slot_addr_s;
            wr_player_d = player_q;
        end else begin
            wr_addr_d   = NO_POS;
            wr_player_d = 1'b0;
        end
        board_full_d = (state_d == S_FULL);
        game_over_d  = (state_d == S_FULL) || (state_d == S_DONE);
    end

    // State, bookkeeping and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            counters_q    <= '0;
            moves_q       <= 5'd0;
            player_q      <= 1'b0;
            col_q         <= 2'd0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= NO_POS;
            wr_player_q   <= 1'b0;
            move_reject_q <= 1'b0;
            board_full_q  <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            counters_q    <= counters_d;
            moves_q       <= moves_d;
            player_q      <= player_d;
            col_q         <= col_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_player_q   <= wr_player_d;
            move_reject_q <= move_reject_d;
            board_full_q  <= board_full_d;
            game_over_q   <= game_over_d;
        end
    end

    assign bus.counters    = counters_q;
    assign bus.wr_en       = wr_en_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_player   = wr_player_q;
    assign bus.player      = player_q;
    assign bus.move_reject = move_reject_q;
    assign bus.board_full  = board_full_q;
    assign bus.game_over   = game_over_q;

endmodule

// File: tb/tb_connect4_turn_controller.sv
// Directed bench for connect4_turn_controller: per-cycle vector table plus
// hand sequences for hold, full board, win and mid-move reset.
module tb_connect4_turn_controller;

    logic clk;
    logic reset_n;
    int   tests;
    int   fails;

    connect4_turn_controller_if bus ();

    connect4_turn_controller dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ng;
        logic [3:0]  btn;
        logic        win;
        logic        wr_en;
        logic [4:0]  addr;
        logic        wrp;
        logic        player;
        logic        rej;
        logic [11:0] cnt;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic ng, input logic [3:0] btn, input logic win,
                                input logic wr_en, input logic [4:0] addr, input logic wrp,
                                input logic player, input logic rej, input logic [11:0] cnt);
        vec_t v;
        v.ng = ng; v.btn = btn; v.win = win; v.wr_en = wr_en; v.addr = addr;
        v.wrp = wrp; v.player = player; v.rej = rej; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outs(input string tag, input logic [11:0] cnt, input logic player);
        chk({tag, " wr_en"}, 32'(bus.wr_en), 32'd0);
        chk({tag, " wr_addr"}, 32'(bus.wr_addr), 32'h1f);
        chk({tag, " move_reject"}, 32'(bus.move_reject), 32'd0);
        chk({tag, " counters"}, 32'(bus.counters), 32'(cnt));
        chk({tag, " player"}, 32'(bus.player), 32'(player));
    endtask

    // Press a column, release it, and check the write plus the state afterwards.
    task automatic do_move(input int col, input logic [4:0] exp_addr, input logic exp_p, input logic last);
        logic [3:0] one;
        one = 4'b0001;
        bus.btn_n = ~(one << col);
        step();
        chk("fill wr_en", 32'(bus.wr_en), 32'd1);
        chk("fill wr_addr", 32'(bus.wr_addr), 32'(exp_addr));
        chk("fill wr_player", 32'(bus.wr_player), 32'(exp_p));
        bus.btn_n = 4'b1111;
        step();
        step();
        chk("fill board_full", 32'(bus.board_full), 32'(last));
        chk("fill game_over", 32'(bus.game_over), 32'(last));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset_n      = 1'b0;
        bus.new_game = 1'b0;
        bus.btn_n    = 4'b1111;
        bus.win      = 1'b0;

        vecs[0]  = mk(1'b1, 4'hF, 1'b0, 1'b0, 5'h1F, 1'b0, 1'b0, 1'b0, 12'h000);
        vecs[1]  = mk(1'b0, 4'h7, 1'b0, 1'b1, 5'h03, 1'b0, 1'b0, 1'b0, 12'h000);
        vecs[2]  = mk(1'b0, 4'h7, 1'b0, 1'b0, 5'h1F, 1'b0, 1'b1, 1'b0, 12'h200);
        vecs[3]  = mk(1'b0, 4'hF, 1'b0, 1'b0, 5'h1F, 1'b0, 1'b1, 1'b0, 12'h200);
        vecs[4]  = mk(1'b0, 4'h7, 1'b0, 1'b1, 5'h07, 1'b1, 1'b1, 1'b0, 12'h200);
        vecs[5]  = mk(1'b0, 4'hF, 1'b0, 1'b0, 5'h1F, 1'b0, 1'b0, 1'b0, 12'h400);
        vecs[6]  = mk(1'b0, 4'hF, 1'b0, 1'b0, 5'h1F, 1'b0, 1'b0, 1'b0, 12'h400);
        vecs[7]  = mk(1'b0, 4'h7, 1'b0, 1'b1, 5'h0B, 1'b0, 1'b0, 1'b0, 12'h400);
        vecs[8]  = mk(1'b0, 4'hF, 1'b0, 1'b0, 5'h1F, 1'b0, 1'b1, 1'b0, 12'h600);
        vecs[9]  = mk(1'b0, 4'hF, 1'b0, 1'b0, 5'h1F, 1'b0, 1'b1, 1'b0, 12'h600);
        vecs[10] = mk(1'b0, 4'h7, 1'b0, 1'b1, 5'h0F, 1'b1, 1'b1, 1'b0, 12'h600);
        vecs[11] = mk(1'b0, 4'hF, 1'b0, 1'b0, 5'h1F, 1'b0, 1'b0, 1'b0, 12'h800);
        vecs[12] = mk(1'b0, 4'hF, 1'b0, 1'b0, 5'h1F, 1'b0, 1'b0, 1'b0, 12'h800);
        vecs[13] = mk(1'b0, 4'h7, 1'b0, 1'b0, 5'h1F, 1'b0, 1'b0, 1'b1, 12'h800);
        vecs[14] = mk(1'b0, 4'hF, 1'b0, 1'b0, 5'h1F, 1'b0, 1'b0, 1'b0, 12'h800);
        vecs[15] = mk(1'b0, 4'hF, 1'b0, 1'b0, 5'h1F, 1'b0, 1'b0, 1'b0, 12'h800);
        vecs[16] = mk(1'b0, 4'hC, 1'b0, 1'b0, 5'h1F, 1'b0, 1'b0, 1'b0, 12'h800);
        vecs[17] = mk(1'b0, 4'hF, 1'b0, 1'b0, 5'h1F, 1'b0, 1'b0, 1'b0, 12'h800);
        vecs[18] = mk(1'b0, 4'hE, 1'b0, 1'b1, 5'h00, 1'b0, 1'b0, 1'b0, 12'h800);
        vecs[19] = mk(1'b0, 4'hE, 1'b0, 1'b0, 5'h1F, 1'b0, 1'b1, 1'b0, 12'h801);

        // Reset values.
        #12;
        chk_idle_outs("reset", 12'h000, 1'b0);
        chk("reset wr_player", 32'(bus.wr_player), 32'd0);
        chk("reset board_full", 32'(bus.board_full), 32'd0);
        chk("reset game_over", 32'(bus.game_over), 32'd0);
        step();
        reset_n = 1'b1;

        // IDLE ignores presses until new_game.
        bus.btn_n = 4'b1110;
        step();
        step();
        chk("idle wr_en", 32'(bus.wr_en), 32'd0);
        bus.btn_n = 4'b1111;
        step();

        for (int i = 0; i < NV; i++) begin
            bus.new_game = vecs[i].ng;
            bus.btn_n    = vecs[i].btn;
            bus.win      = vecs[i].win;
            step();
            bus.new_game = 1'b0;
            tests++;
            if (bus.wr_en !== vecs[i].wr_en || bus.wr_addr !== vecs[i].addr ||
                bus.wr_player !== vecs[i].wrp || bus.player !== vecs[i].player ||
                bus.move_reject !== vecs[i].rej || bus.counters !== vecs[i].cnt ||
                bus.game_over !== 1'b0 || bus.board_full !== 1'b0) begin
                fails++;
                $display("FAIL vec%0d: got wr_en=%b addr=%h wrp=%b player=%b rej=%b cnt=%h go=%b bf=%b expected wr_en=%b addr=%h wrp=%b player=%b rej=%b cnt=%h go=0 bf=0",
                         i, bus.wr_en, bus.wr_addr, bus.wr_player, bus.player, bus.move_reject,
                         bus.counters, bus.game_over, bus.board_full, vecs[i].wr_en, vecs[i].addr,
                         vecs[i].wrp, vecs[i].player, vecs[i].rej, vecs[i].cnt);
            end
        end

        // Button still held: no further writes.
        for (int i = 0; i < 20; i++) begin
            step();
            chk("hold wr_en", 32'(bus.wr_en), 32'd0);
        end
        chk("hold counters", 32'(bus.counters), 32'h801);

        // Fill the whole board with no win.
        bus.btn_n    = 4'b1111;
        bus.new_game = 1'b1;
        step();
        bus.new_game = 1'b0;
        chk("newgame counters", 32'(bus.counters), 32'h000);
        for (int i = 0; i < 16; i++) begin
            do_move(i % 4, 5'((i / 4) * 4 + (i % 4)), 1'(i % 2), (i == 15));
        end
        chk("full counters", 32'(bus.counters), 32'h924);
        bus.btn_n = 4'b1110;
        step();
        chk("full press wr_en", 32'(bus.wr_en), 32'd0);
        step();
        chk("full press reject", 32'(bus.move_reject), 32'd0);
        chk("full frozen", 32'(bus.counters), 32'h924);
        bus.btn_n    = 4'b1111;
        bus.new_game = 1'b1;
        step();
        bus.new_game = 1'b0;
        chk("clear counters", 32'(bus.counters), 32'h000);
        chk("clear board_full", 32'(bus.board_full), 32'd0);
        chk("clear game_over", 32'(bus.game_over), 32'd0);

        // Win during the PLACE write: write completes, game ends.
        bus.btn_n = 4'b1101;
        step();
        chk("win wr_en", 32'(bus.wr_en), 32'd1);
        chk("win wr_addr", 32'(bus.wr_addr), 32'h01);
        bus.win   = 1'b1;
        bus.btn_n = 4'b1111;
        step();
        bus.win = 1'b0;
        chk("win counters", 32'(bus.counters), 32'h008);
        chk("win player", 32'(bus.player), 32'd1);
        chk("win game_over", 32'(bus.game_over), 32'd1);
        chk("win board_full", 32'(bus.board_full), 32'd0);
        bus.btn_n = 4'b1101;
        step();
        chk("done press wr_en", 32'(bus.wr_en), 32'd0);
        step();
        chk("done counters", 32'(bus.counters), 32'h008);
        bus.btn_n = 4'b1111;

        // Asynchronous reset in the middle of a PLACE write.
        bus.new_game = 1'b1;
        step();
        bus.new_game = 1'b0;
        bus.btn_n    = 4'b1011;
        step();
        chk("pre-reset wr_en", 32'(bus.wr_en), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_idle_outs("async reset", 12'h000, 1'b0);
        chk("async reset game_over", 32'(bus.game_over), 32'd0);
        step();
        reset_n = 1'b1;
        step();
        step();
        chk_idle_outs("post reset idle", 12'h000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
